// File: rtl/rv32_exec_pkg.sv
// Shared encodings for the RV32 execute-stage slice: ALU ops, operand selects,
// branch conditions, CSR ops and CSR addresses.
package rv32_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_A_RS1 = 3'd0,
    SRC_A_PC  = 3'd1
  } src_a_e;

  typedef enum logic [2:0] {
    SRC_B_RS2  = 3'd0,
    SRC_B_IMM  = 3'd1,
    SRC_B_FOUR = 3'd2
  } src_b_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_cond_e;

  typedef enum logic [2:0] {
    CSR_NONE  = 3'd0,
    CSR_RW    = 3'd1,
    CSR_RS    = 3'd2,
    CSR_ECALL = 3'd3,
    CSR_MRET  = 3'd4
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_ECALL = 32'd11;

endpackage

// File: rtl/rv32_exec_alu.sv
// Combinational ALU and branch comparator. The comparator looks at the raw
// register values, not at the muxed ALU operands.
module rv32_exec_alu
  import rv32_exec_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  alu_ctl_i,
  input  logic [31:0] cmp_a_i,
  input  logic [31:0] cmp_b_i,
  input  logic        cmp_en_i,
  input  logic [2:0]  cmp_cond_i,
  output logic [31:0] alu_out_o,
  output logic        br_taken_o
);

  logic [4:0] shamt;
  logic       cond;

  assign shamt = b_i[4:0];

  always_comb begin
    alu_out_o = '0;
    case (alu_ctl_i)
      ALU_ADD:   alu_out_o = a_i + b_i;
      ALU_SUB:   alu_out_o = a_i - b_i;
      ALU_SLL:   alu_out_o = a_i << shamt;
      ALU_SLT:   alu_out_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  alu_out_o = {31'd0, a_i < b_i};
      ALU_XOR:   alu_out_o = a_i ^ b_i;
      ALU_SRL:   alu_out_o = a_i >> shamt;
      ALU_SRA:   alu_out_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    alu_out_o = a_i | b_i;
      ALU_AND:   alu_out_o = a_i & b_i;
      ALU_PASSB: alu_out_o = b_i;
      default:   alu_out_o = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (cmp_cond_i)
      BR_EQ:   cond = (cmp_a_i == cmp_b_i);
      BR_NE:   cond = (cmp_a_i != cmp_b_i);
      BR_LT:   cond = ($signed(cmp_a_i) < $signed(cmp_b_i));
      BR_GE:   cond = ($signed(cmp_a_i) >= $signed(cmp_b_i));
      BR_LTU:  cond = (cmp_a_i < cmp_b_i);
      BR_GEU:  cond = (cmp_a_i >= cmp_b_i);
      default: cond = 1'b0;
    endcase
  end

  assign br_taken_o = cmp_en_i & cond;

endmodule

// File: rtl/rv32_exec_core.sv
// RV32 execute-stage slice: GPR file, machine-mode CSR file, operand muxes
// and the ALU/branch sub-module. Reads are combinational; state changes at the edge.
module rv32_exec_core
  import rv32_exec_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd,
  input  logic        RegWr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [2:0]  rs1_ctr,
  input  logic [2:0]  rs2_ctr,
  input  logic [3:0]  alu_ctl,
  input  logic        Equal_ctl,
  input  logic [2:0]  eq_ctl,
  output logic [31:0] alu_out,
  output logic        rd_wirte,
  input  logic [2:0]  csrs_ctl,
  input  logic [11:0] csrs_rs1_read_add,
  output logic [31:0] csr_rdata,
  output logic [31:0] csr_next_pc
);

  logic [31:0] gpr_q [32];
  logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
  logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] op_a, op_b;

  // No write bypass: a read of the register being written returns the old value.
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : gpr_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : gpr_q[rs2_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (RegWr && (rd != 5'd0)) begin
      gpr_q[rd] <= rd_data;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csrs_rs1_read_add)
      CSR_MSTATUS: csr_rdata = mstatus_q;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    csr_wen   = 1'b0;
    csr_wdata = '0;
    case (csrs_ctl)
      CSR_RW: begin
        csr_wen   = 1'b1;
        csr_wdata = rs1_data;
      end
      CSR_RS: begin
        csr_wen   = 1'b1;
        csr_wdata = csr_rdata | rs1_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (csr_wen) begin
      case (csrs_rs1_read_add)
        CSR_MSTATUS: mstatus_d = csr_wdata;
        CSR_MTVEC:   mtvec_d   = csr_wdata;
        CSR_MEPC:    mepc_d    = csr_wdata;
        CSR_MCAUSE:  mcause_d  = csr_wdata;
        default: ;
      endcase
    end else if (csrs_ctl == CSR_ECALL) begin
      mepc_d   = pc;
      mcause_d = MCAUSE_ECALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q <= RESET_MSTATUS;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  always_comb begin
    csr_next_pc = pc + 32'd4;
    case (csrs_ctl)
      CSR_ECALL: csr_next_pc = mtvec_q;
      CSR_MRET:  csr_next_pc = mepc_q;
      default: ;
    endcase
  end

  always_comb begin
    op_a = '0;
    case (rs1_ctr)
      SRC_A_RS1: op_a = rs1_data;
      SRC_A_PC:  op_a = pc;
      default:   op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    case (rs2_ctr)
      SRC_B_RS2:  op_b = rs2_data;
      SRC_B_IMM:  op_b = imm;
      SRC_B_FOUR: op_b = 32'd4;
      default:    op_b = '0;
    endcase
  end

  rv32_exec_alu u_alu (
    .a_i        (op_a),
    .b_i        (op_b),
    .alu_ctl_i  (alu_ctl),
    .cmp_a_i    (rs1_data),
    .cmp_b_i    (rs2_data),
    .cmp_en_i   (Equal_ctl),
    .cmp_cond_i (eq_ctl),
    .alu_out_o  (alu_out),
    .br_taken_o (rd_wirte)
  );

endmodule

// File: tb/tb_rv32_exec_core.sv
// Directed and randomized checks of rv32_exec_core against a behavioural model.
module tb_rv32_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, imm, rd_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic        RegWr, Equal_ctl;
  logic [2:0]  rs1_ctr, rs2_ctr, eq_ctl, csrs_ctl;
  logic [3:0]  alu_ctl;
  logic [11:0] csrs_rs1_read_add;
  logic [31:0] rs1_data, rs2_data, alu_out, csr_rdata, csr_next_pc;
  logic        rd_wirte;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] m_gpr [32];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  rv32_exec_core #(.RESET_MSTATUS(32'h0000_1800)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd(rd),
    .RegWr(RegWr), .rd_data(rd_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ctr(rs1_ctr), .rs2_ctr(rs2_ctr), .alu_ctl(alu_ctl),
    .Equal_ctl(Equal_ctl), .eq_ctl(eq_ctl),
    .alu_out(alu_out), .rd_wirte(rd_wirte),
    .csrs_ctl(csrs_ctl), .csrs_rs1_read_add(csrs_rs1_read_add),
    .csr_rdata(csr_rdata), .csr_next_pc(csr_next_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_mstatus = 32'h0000_1800;
    m_mtvec = 0;
    m_mepc = 0;
    m_mcause = 0;
  endtask

  function automatic logic [31:0] m_read_gpr(input logic [4:0] a);
    return (a == 0) ? 32'd0 : m_gpr[a];
  endfunction

  function automatic logic [31:0] m_read_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    sh = b % 32;
    sa = a;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: begin
        for (int i = 0; i < 32; i++) if (i < sh) sa = sa / 2 - ((sa % 2 != 0 && sa < 0) ? 1 : 0);
        return sa;
      end
      8: return a | b;
      9: return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_branch(input logic en, input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    logic r;
    case (c)
      0: r = (x == y);
      1: r = (x != y);
      4: r = ($signed(x) < $signed(y));
      5: r = !($signed(x) < $signed(y));
      6: r = (x < y);
      7: r = !(x < y);
      default: r = 1'b0;
    endcase
    return en && r;
  endfunction

  // Commit the current inputs into the model, then advance past the edge.
  task automatic cycle();
    logic [31:0] old_rs1, old_csr;
    old_rs1 = m_read_gpr(rs1_addr);
    old_csr = m_read_csr(csrs_rs1_read_add);
    if (csrs_ctl == 1 || csrs_ctl == 2) begin
      logic [31:0] w;
      w = (csrs_ctl == 1) ? old_rs1 : (old_csr | old_rs1);
      case (csrs_rs1_read_add)
        12'h300: m_mstatus = w;
        12'h305: m_mtvec = w;
        12'h341: m_mepc = w;
        12'h342: m_mcause = w;
        default: ;
      endcase
    end else if (csrs_ctl == 3) begin
      m_mepc = pc;
      m_mcause = 32'd11;
    end
    if (RegWr && rd != 0) m_gpr[rd] = rd_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc = 0; imm = 0; rs1_addr = 0; rs2_addr = 0; rd = 0; RegWr = 0; rd_data = 0;
    rs1_ctr = 0; rs2_ctr = 0; alu_ctl = 0; Equal_ctl = 0; eq_ctl = 0;
    csrs_ctl = 0; csrs_rs1_read_add = 0;
  endtask

  task automatic write_gpr(input logic [4:0] r, input logic [31:0] v);
    idle();
    RegWr = 1; rd = r; rd_data = v;
    cycle();
    idle();
  endtask

  initial begin
    logic [31:0] a, b;
    logic [11:0] addrs [6];
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
    addrs[3] = 12'h342; addrs[4] = 12'h7C0; addrs[5] = 12'h000;

    rst = 1;
    idle();
    model_reset();
    #2;
    rs1_addr = 5; csrs_rs1_read_add = 12'h300;
    #1;
    check("reset_rs1", rs1_data, 32'd0);
    check("reset_mstatus", csr_rdata, 32'h0000_1800);
    check("reset_next_pc", csr_next_pc, 32'd4);
    @(posedge clk); #1;
    rst = 0;
    idle();

    // GPR write/read, same-cycle read returns old value
    RegWr = 1; rd = 3; rd_data = 32'hDEAD_BEEF; rs1_addr = 3;
    #1;
    check("same_cycle_old", rs1_data, 32'd0);
    cycle();
    idle(); rs1_addr = 3; #1;
    check("gpr_x3", rs1_data, 32'hDEAD_BEEF);
    write_gpr(0, 32'hFFFF_FFFF);
    rs1_addr = 0; rs2_addr = 0; #1;
    check("x0_rs1", rs1_data, 32'd0);
    check("x0_rs2", rs2_data, 32'd0);

    // ALU directed
    idle(); rs1_ctr = 1; rs2_ctr = 1; pc = 32'h7FFF_FFFF; imm = 1; alu_ctl = 0; #1;
    check("add_wrap", alu_out, 32'h8000_0000);
    rs1_ctr = 3; alu_ctl = 1; #1;
    check("sub_0_1", alu_out, 32'hFFFF_FFFF);
    rs1_ctr = 1; pc = 32'h8000_0000; imm = 4; alu_ctl = 7; #1;
    check("sra", alu_out, 32'hF800_0000);
    alu_ctl = 6; #1;
    check("srl", alu_out, 32'h0800_0000);
    pc = 32'hFFFF_FFFF; imm = 1; alu_ctl = 3; #1;
    check("slt", alu_out, 32'd1);
    alu_ctl = 4; #1;
    check("sltu", alu_out, 32'd0);
    alu_ctl = 12; #1;
    check("op12_zero", alu_out, 32'd0);
    pc = 32'h8000_0000; rs2_ctr = 2; alu_ctl = 0; #1;
    check("pc_plus4", alu_out, 32'h8000_0004);

    // Branch
    write_gpr(1, 32'hFFFF_FFFF);
    write_gpr(2, 32'd1);
    rs1_addr = 1; rs2_addr = 2; Equal_ctl = 1; rs2_ctr = 2;
    eq_ctl = 4; #1; check("br_lt", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 6; #1; check("br_ltu", {31'd0, rd_wirte}, 32'd0);
    eq_ctl = 5; #1; check("br_ge", {31'd0, rd_wirte}, 32'd0);
    eq_ctl = 7; #1; check("br_geu", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 2; #1; check("br_cond2", {31'd0, rd_wirte}, 32'd0);
    Equal_ctl = 0; eq_ctl = 4; #1; check("br_disabled", {31'd0, rd_wirte}, 32'd0);

    // CSR trap flow
    write_gpr(4, 32'h8000_0100);
    rs1_addr = 4; csrs_ctl = 1; csrs_rs1_read_add = 12'h305;
    cycle();
    idle(); csrs_rs1_read_add = 12'h305; #1;
    check("mtvec_rw", csr_rdata, 32'h8000_0100);
    pc = 32'h8000_0040; csrs_ctl = 3; #1;
    check("ecall_target", csr_next_pc, 32'h8000_0100);
    cycle();
    idle(); csrs_rs1_read_add = 12'h341; #1;
    check("mepc", csr_rdata, 32'h8000_0040);
    csrs_rs1_read_add = 12'h342; #1;
    check("mcause", csr_rdata, 32'd11);
    csrs_ctl = 4; pc = 32'h1000; #1;
    check("mret_target", csr_next_pc, 32'h8000_0040);
    cycle();
    idle(); csrs_rs1_read_add = 12'h342; #1;
    check("mret_no_change", csr_rdata, 32'd11);

    // CSRRS and unsupported address
    write_gpr(6, 32'h8);
    rs1_addr = 6; csrs_ctl = 2; csrs_rs1_read_add = 12'h300; #1;
    check("csrrs_old", csr_rdata, 32'h1800);
    cycle();
    idle(); csrs_rs1_read_add = 12'h300; #1;
    check("csrrs_new", csr_rdata, 32'h1808);
    rs1_addr = 6; csrs_ctl = 1; csrs_rs1_read_add = 12'h7C0;
    cycle();
    idle(); csrs_rs1_read_add = 12'h7C0; #1;
    check("unsupported", csr_rdata, 32'd0);

    // CSRRW with rs1 == rd: CSR gets the old GPR value, GPR also written
    rs1_addr = 3; rd = 3; RegWr = 1; rd_data = 32'h55; csrs_ctl = 1; csrs_rs1_read_add = 12'h342;
    cycle();
    idle(); rs1_addr = 3; csrs_rs1_read_add = 12'h342; #1;
    check("rw_same_csr", csr_rdata, 32'hDEAD_BEEF);
    check("rw_same_gpr", rs1_data, 32'h55);

    // Mid-cycle asynchronous reset
    write_gpr(5, 32'h1234);
    rs1_addr = 5; #1;
    check("pre_reset_x5", rs1_data, 32'h1234);
    #2;
    rst = 1; rd = 5; RegWr = 1; rd_data = 32'h99; csrs_rs1_read_add = 12'h300;
    #1;
    check("async_reset_x5", rs1_data, 32'd0);
    check("async_reset_mstatus", csr_rdata, 32'h1800);
    @(posedge clk); #1;
    check("no_write_in_reset", rs1_data, 32'd0);
    rst = 0;
    idle();
    model_reset();

    // Randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      pc = $urandom; imm = $urandom;
      if ($urandom_range(0, 3) == 0) imm = $urandom_range(0, 40);
      rs1_addr = 5'($urandom_range(0, 31)); rs2_addr = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); RegWr = 1'($urandom_range(0, 1));
      rd_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs1_ctr = 3'($urandom_range(0, 7)); rs2_ctr = 3'($urandom_range(0, 7));
      alu_ctl = 4'($urandom_range(0, 15));
      Equal_ctl = 1'($urandom_range(0, 1)); eq_ctl = 3'($urandom_range(0, 7));
      csrs_ctl = 3'($urandom_range(0, 7));
      csrs_rs1_read_add = addrs[$urandom_range(0, 5)];
      #1;
      a = (rs1_ctr == 0) ? m_read_gpr(rs1_addr) : (rs1_ctr == 1) ? pc : 32'd0;
      b = (rs2_ctr == 0) ? m_read_gpr(rs2_addr) : (rs2_ctr == 1) ? imm :
          (rs2_ctr == 2) ? 32'd4 : 32'd0;
      check("rnd_rs1", rs1_data, m_read_gpr(rs1_addr));
      check("rnd_rs2", rs2_data, m_read_gpr(rs2_addr));
      check("rnd_alu", alu_out, m_alu(alu_ctl, a, b));
      check("rnd_br", {31'd0, rd_wirte},
            {31'd0, m_branch(Equal_ctl, eq_ctl, m_read_gpr(rs1_addr), m_read_gpr(rs2_addr))});
      check("rnd_csr", csr_rdata, m_read_csr(csrs_rs1_read_add));
      check("rnd_npc", csr_next_pc,
            (csrs_ctl == 3) ? m_mtvec : (csrs_ctl == 4) ? m_mepc : pc + 32'd4);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
